// File: rtl/mem_line_responder_pkg.sv
// Shared types and sizing for the memory-side line responder.
package mem_line_responder_pkg;

  localparam int XLEN             = 32;
  localparam int CACHELINE_SIZE   = 256;
  localparam int NUM_CACHE        = 8;
  localparam int SRC_W            = $clog2(NUM_CACHE) + 1;
  localparam int WAY_W            = 2;
  localparam int BURST_WIDTH      = 64;
  localparam int BURST_LEN        = CACHELINE_SIZE / BURST_WIDTH;
  localparam int CNT_W            = $clog2(BURST_LEN);
  localparam int LINE_OFFSET_BITS = $clog2(CACHELINE_SIZE / 8);

  // Memory answers with an id one past the last cache id.
  localparam logic [SRC_W-1:0] MEM_ID = SRC_W'(NUM_CACHE);

  typedef enum logic [1:0] {NONE, GETS, GETM, PUTM} bus_tx_t;
  typedef enum logic [1:0] {NODATA, DATA, EXCLUSIVE} mmsg_t;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_CMD, S_RD_BEAT, S_WB_WAIT, S_WR_BEAT, S_RESP
  } mem_resp_state_t;

  typedef struct packed {
    logic              valid;
    bus_tx_t           bus_tx;
    logic [XLEN-1:0]   addr;
    logic [SRC_W-1:0]  source;
  } req_msg_t;

  typedef struct packed {
    logic                      valid;
    mmsg_t                     mmsg;
    logic [SRC_W-1:0]          source;
    logic [SRC_W-1:0]          destination;
    logic                      memory_flag;
    logic [WAY_W-1:0]          way;
    logic [XLEN-1:0]           addr;
    logic [CACHELINE_SIZE-1:0] data;
  } resp_msg_t;

  // Clear the byte-within-line offset so the address names a whole line.
  function automatic logic [XLEN-1:0] line_addr(input logic [XLEN-1:0] a);
    return a & ~(XLEN'((1 << LINE_OFFSET_BITS) - 1));
  endfunction

endpackage

// File: rtl/mem_line_responder.sv
// Memory-side terminator for cache requests: burst-reads lines for GETS/GETM,
// burst-writes evicted lines for PUTM, and answers the requestor.
module mem_line_responder
  import mem_line_responder_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  req_msg_t               req_i,
  input  logic                   req_excl_i,
  output logic                   req_ready_o,
  input  resp_msg_t              wb_i,
  output resp_msg_t              resp_o,
  input  logic                   resp_ready_i,
  output logic [XLEN-1:0]        bmem_addr_o,
  output logic                   bmem_read_o,
  output logic                   bmem_write_o,
  output logic [BURST_WIDTH-1:0] bmem_wdata_o,
  input  logic                   bmem_ready_i,
  input  logic [BURST_WIDTH-1:0] bmem_rdata_i,
  input  logic                   bmem_rvalid_i
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  mem_resp_state_t             r_state;
  logic [CNT_W-1:0]            r_cnt;
  logic [CACHELINE_SIZE-1:0]   r_data;
  logic [XLEN-1:0]             r_addr;
  logic [SRC_W-1:0]            r_src;
  bus_tx_t                     r_tx;
  logic                        r_excl;
  logic                        r_req_ready;
  logic                        r_bmem_read;
  logic                        r_bmem_write;
  logic [BURST_WIDTH-1:0]      r_bmem_wdata;
  resp_msg_t                   r_resp;

  logic [CNT_W-1:0]            w_cnt_inc;
  logic                        w_wb_match;
  resp_msg_t                   w_resp;
  logic                        w_unused_wb;

  assign w_cnt_inc  = r_cnt + 1'b1;
  assign w_wb_match = wb_i.valid && wb_i.memory_flag && (line_addr(wb_i.addr) == r_addr);
  // Only the data/address half of the writeback message matters here.
  assign w_unused_wb = ^{wb_i.mmsg, wb_i.source, wb_i.destination, wb_i.way};

  assign req_ready_o  = r_req_ready;
  assign bmem_addr_o  = r_addr;
  assign bmem_read_o  = r_bmem_read;
  assign bmem_write_o = r_bmem_write;
  assign bmem_wdata_o = r_bmem_wdata;
  assign resp_o       = r_resp;

  // Response loaded on entry to S_RESP; for reads the final beat is still on the bus.
  always_comb begin
    w_resp             = '0;
    w_resp.valid       = 1'b1;
    w_resp.source      = MEM_ID;
    w_resp.destination = r_src;
    w_resp.addr        = r_addr;
    case (r_tx)
      GETS:    w_resp.mmsg = r_excl ? EXCLUSIVE : DATA;
      GETM:    w_resp.mmsg = DATA;
      default: w_resp.mmsg = NODATA;
    endcase
    if (r_tx != PUTM) begin
      w_resp.data = {bmem_rdata_i, r_data[CACHELINE_SIZE-BURST_WIDTH-1:0]};
    end
  end

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_data       <= '0;
      r_addr       <= '0;
      r_src        <= '0;
      r_tx         <= NONE;
      r_excl       <= 1'b0;
      r_req_ready  <= 1'b1;
      r_bmem_read  <= 1'b0;
      r_bmem_write <= 1'b0;
      r_bmem_wdata <= '0;
      r_resp       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // NONE requests are taken and silently dropped.
          if (req_i.valid && req_i.bus_tx != NONE) begin
            r_addr      <= line_addr(req_i.addr);
            r_src       <= req_i.source;
            r_tx        <= req_i.bus_tx;
            r_excl      <= req_excl_i;
            r_req_ready <= 1'b0;
            if (req_i.bus_tx == PUTM) begin
              r_state <= S_WB_WAIT;
            end else begin
              r_state     <= S_RD_CMD;
              r_bmem_read <= 1'b1;
            end
          end
        end
        S_RD_CMD: begin
          if (bmem_ready_i) begin
            r_bmem_read <= 1'b0;
            r_state     <= S_RD_BEAT;
          end
        end
        S_RD_BEAT: begin
          if (bmem_rvalid_i) begin
            r_data[BURST_WIDTH*r_cnt +: BURST_WIDTH] <= bmem_rdata_i;
            if (r_cnt == LAST_BEAT) begin
              r_cnt   <= '0;
              r_resp  <= w_resp;
              r_state <= S_RESP;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
        end
        S_WB_WAIT: begin
          if (w_wb_match) begin
            r_data       <= wb_i.data;
            r_cnt        <= '0;
            r_bmem_write <= 1'b1;
            r_bmem_wdata <= wb_i.data[BURST_WIDTH-1:0];
            r_state      <= S_WR_BEAT;
          end
        end
        S_WR_BEAT: begin
          if (bmem_ready_i) begin
            if (r_cnt == LAST_BEAT) begin
              r_cnt        <= '0;
              r_bmem_write <= 1'b0;
              r_bmem_wdata <= '0;
              r_resp       <= w_resp;
              r_state      <= S_RESP;
            end else begin
              r_cnt        <= w_cnt_inc;
              r_bmem_wdata <= r_data[BURST_WIDTH*w_cnt_inc +: BURST_WIDTH];
            end
          end
        end
        S_RESP: begin
          if (resp_ready_i) begin
            r_resp      <= '0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_line_responder.sv
// Directed bench for mem_line_responder with hand-computed expectations.
module tb_mem_line_responder;
  import mem_line_responder_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  req_msg_t               req_i = '0;
  logic                   req_excl_i = 1'b0;
  logic                   req_ready_o;
  resp_msg_t              wb_i = '0;
  resp_msg_t              resp_o;
  logic                   resp_ready_i = 1'b0;
  logic [XLEN-1:0]        bmem_addr_o;
  logic                   bmem_read_o;
  logic                   bmem_write_o;
  logic [BURST_WIDTH-1:0] bmem_wdata_o;
  logic                   bmem_ready_i = 1'b1;
  logic [BURST_WIDTH-1:0] bmem_rdata_i = '0;
  logic                   bmem_rvalid_i = 1'b0;

  int n_total = 0;
  int n_bad   = 0;

  logic [63:0] beats [4];

  mem_line_responder dut (
    .clk           (clk),
    .rst           (rst),
    .req_i         (req_i),
    .req_excl_i    (req_excl_i),
    .req_ready_o   (req_ready_o),
    .wb_i          (wb_i),
    .resp_o        (resp_o),
    .resp_ready_i  (resp_ready_i),
    .bmem_addr_o   (bmem_addr_o),
    .bmem_read_o   (bmem_read_o),
    .bmem_write_o  (bmem_write_o),
    .bmem_wdata_o  (bmem_wdata_o),
    .bmem_ready_i  (bmem_ready_i),
    .bmem_rdata_i  (bmem_rdata_i),
    .bmem_rvalid_i (bmem_rvalid_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bus_tx_t tx, input logic [31:0] a, input logic [3:0] s, input logic ex);
    req_i.valid  = 1'b1;
    req_i.bus_tx = tx;
    req_i.addr   = a;
    req_i.source = s;
    req_excl_i   = ex;
    tick();
    req_i      = '0;
    req_excl_i = 1'b0;
  endtask

  task automatic beat(input logic [63:0] d);
    bmem_rvalid_i = 1'b1;
    bmem_rdata_i  = d;
    tick();
    bmem_rvalid_i = 1'b0;
    bmem_rdata_i  = '0;
  endtask

  task automatic take_resp();
    resp_ready_i = 1'b1;
    tick();
    resp_ready_i = 1'b0;
    chk("idle_resp_valid", resp_o.valid, 0);
    chk("idle_req_ready", req_ready_o, 1);
  endtask

  initial begin
    // ---------------- reset state ----------------
    tick();
    tick();
    chk("rst_req_ready", req_ready_o, 1);
    chk("rst_read", bmem_read_o, 0);
    chk("rst_write", bmem_write_o, 0);
    chk("rst_addr", bmem_addr_o, 0);
    chk("rst_resp", resp_o, 0);
    rst = 1'b0;
    tick();

    // ---------------- GETS exclusive ----------------
    beats[0] = 64'h1111_1111_1111_1111;
    beats[1] = 64'h2222_2222_2222_2222;
    beats[2] = 64'h3333_3333_3333_3333;
    beats[3] = 64'h4444_4444_4444_4444;
    issue(GETS, 32'h0000_1234, 4'd3, 1'b1);
    chk("t1_read_cmd", bmem_read_o, 1);
    chk("t1_addr", bmem_addr_o, 32'h0000_1220);
    chk("t1_req_ready", req_ready_o, 0);
    tick();
    chk("t1_read_drop", bmem_read_o, 0);
    for (int i = 0; i < 4; i++) begin
      beat(beats[i]);
      chk("t1_resp_valid", resp_o.valid, (i == 3) ? 1 : 0);
    end
    chk("t1_dest", resp_o.destination, 3);
    chk("t1_src", resp_o.source, 8);
    chk("t1_mmsg", resp_o.mmsg, EXCLUSIVE);
    chk("t1_flag", resp_o.memory_flag, 0);
    chk("t1_raddr", resp_o.addr, 32'h0000_1220);
    chk("t1_data", resp_o.data, {beats[3], beats[2], beats[1], beats[0]});
    take_resp();
    $display("txn GETS 0x00001234 src=3 excl done");

    // ---------------- GETM with stalls, gaps, backpressure ----------------
    beats[0] = 64'hB000_0000_0000_00B0;
    beats[1] = 64'hB100_0000_0000_00B1;
    beats[2] = 64'hB200_0000_0000_00B2;
    beats[3] = 64'hB300_0000_0000_00B3;
    bmem_ready_i = 1'b0;
    issue(GETM, 32'h0000_2047, 4'd5, 1'b1);
    for (int k = 0; k < 3; k++) begin
      chk("t2_read_hold", bmem_read_o, 1);
      tick();
    end
    bmem_ready_i = 1'b1;
    chk("t2_read_4th", bmem_read_o, 1);
    chk("t2_addr", bmem_addr_o, 32'h0000_2040);
    tick();
    chk("t2_read_done", bmem_read_o, 0);
    beat(beats[0]);
    tick();
    beat(beats[1]);
    tick();
    tick();
    beat(beats[2]);
    chk("t2_not_yet", resp_o.valid, 0);
    beat(beats[3]);
    for (int k = 0; k < 5; k++) begin
      chk("t2_bp_valid", resp_o.valid, 1);
      chk("t2_bp_mmsg", resp_o.mmsg, DATA);
      chk("t2_bp_dest", resp_o.destination, 5);
      chk("t2_bp_data", resp_o.data, {beats[3], beats[2], beats[1], beats[0]});
      chk("t2_bp_req_ready", req_ready_o, 0);
      tick();
    end
    take_resp();
    $display("txn GETM 0x00002047 src=5 stalls+backpressure done");

    // ---------------- PUTM with writeback filtering ----------------
    beats[0] = 64'hA5A5_A5A5_A5A5_A5A0;
    beats[1] = 64'hA5A5_A5A5_A5A5_A5A1;
    beats[2] = 64'hA5A5_A5A5_A5A5_A5A2;
    beats[3] = 64'hA5A5_A5A5_A5A5_A5A3;
    issue(PUTM, 32'h8000_0040, 4'd2, 1'b0);
    chk("t3_no_read", bmem_read_o, 0);
    chk("t3_req_ready", req_ready_o, 0);
    wb_i             = '0;
    wb_i.valid       = 1'b1;
    wb_i.memory_flag = 1'b1;
    wb_i.addr        = 32'h8000_0060;
    wb_i.data        = {4{64'hDEAD_BEEF_DEAD_BEEF}};
    tick();
    chk("t3_wrong_addr", bmem_write_o, 0);
    wb_i.addr        = 32'h8000_0044;
    wb_i.memory_flag = 1'b0;
    tick();
    chk("t3_no_mem_flag", bmem_write_o, 0);
    wb_i.memory_flag = 1'b1;
    wb_i.data        = {beats[3], beats[2], beats[1], beats[0]};
    tick();
    wb_i = '0;
    for (int b = 0; b < 4; b++) begin
      if (b == 1 || b == 2) begin
        bmem_ready_i = 1'b0;
        tick();
        chk("t3_stall_strobe", bmem_write_o, 1);
        chk("t3_stall_data", bmem_wdata_o, beats[b]);
        bmem_ready_i = 1'b1;
      end
      chk("t3_wr_strobe", bmem_write_o, 1);
      chk("t3_wr_data", bmem_wdata_o, beats[b]);
      chk("t3_wr_addr", bmem_addr_o, 32'h8000_0040);
      tick();
    end
    chk("t3_wr_end", bmem_write_o, 0);
    chk("t3_resp_valid", resp_o.valid, 1);
    chk("t3_mmsg", resp_o.mmsg, NODATA);
    chk("t3_dest", resp_o.destination, 2);
    chk("t3_src", resp_o.source, 8);
    chk("t3_data", resp_o.data, 0);
    take_resp();
    $display("txn PUTM 0x80000040 src=2 done");

    // ---------------- reset mid-burst, then a fresh read ----------------
    issue(GETS, 32'h0000_0300, 4'd1, 1'b0);
    tick();
    beat(64'hEEEE_0000_0000_0000);
    beat(64'hEEEE_0000_0000_0001);
    beat(64'hEEEE_0000_0000_0002);
    rst = 1'b1;
    #1;
    chk("t5_rst_req_ready", req_ready_o, 1);
    chk("t5_rst_read", bmem_read_o, 0);
    chk("t5_rst_addr", bmem_addr_o, 0);
    chk("t5_rst_resp", resp_o, 0);
    tick();
    rst = 1'b0;
    tick();
    beats[0] = 64'h0F0F_0000_0000_0000;
    beats[1] = 64'h0F0F_0000_0000_0001;
    beats[2] = 64'h0F0F_0000_0000_0002;
    beats[3] = 64'h0F0F_0000_0000_0003;
    issue(GETS, 32'h0000_0300, 4'd1, 1'b0);
    chk("t5_read_cmd", bmem_read_o, 1);
    tick();
    for (int i = 0; i < 4; i++) beat(beats[i]);
    chk("t5_resp_valid", resp_o.valid, 1);
    chk("t5_mmsg", resp_o.mmsg, DATA);
    chk("t5_data", resp_o.data, {beats[3], beats[2], beats[1], beats[0]});
    take_resp();
    $display("txn reset mid-burst + GETS 0x00000300 src=1 done");

    // ---------------- NONE requests are dropped ----------------
    req_i.valid  = 1'b1;
    req_i.bus_tx = NONE;
    req_i.addr   = 32'h0000_5000;
    req_i.source = 4'd4;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t6_req_ready", req_ready_o, 1);
      chk("t6_no_read", bmem_read_o, 0);
      chk("t6_no_resp", resp_o.valid, 0);
    end
    req_i = '0;
    $display("txn NONE dropped done");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_line_responder.md
Name: mem_line_responder

Overview:
- Memory-side responder on the coherence bus: the terminating end for cache requests that the LLC routes to memory.
- GETS/GETM: reads a 256-bit line from the burst memory port as 4 × 64-bit beats, deserializes it, and returns a resp_msg_t to the requestor.
- PUTM: captures the evicting cache's data response (memory_flag=1), serializes it into a 4-beat write burst, then sends a NODATA acknowledgement.
- Sits between the bus request/response channels and the backing memory model.

Parameters:
- BURST_WIDTH, 64: bits per memory beat.
- BURST_LEN, CACHELINE_SIZE/BURST_WIDTH (=4): beats per line.
- MEM_ID, NUM_CACHE (=8): value driven in resp.source; fits the $clog2(NUM_CACHE)+1-bit field.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req_i  in  req_msg_t  routed bus request; accepted when req_i.valid && req_ready_o.
- req_excl_i  in  1  sampled with an accepted GETS; 1 = no sharers, so answer EXCLUSIVE.
- req_ready_o  out  1  high only in S_IDLE.
- wb_i  in  resp_msg_t  writeback data from the evicting cache.
- resp_o  out  resp_msg_t  response to the requestor; held stable until taken.
- resp_ready_i  in  1  consumer accepts resp_o when resp_o.valid && resp_ready_i.
- bmem_addr_o  out  XLEN  line-aligned address; bits [4:0] are always 0.
- bmem_read_o  out  1  read-burst command.
- bmem_write_o  out  1  write beat strobe.
- bmem_wdata_o  out  BURST_WIDTH  write beat data.
- bmem_ready_i  in  1  memory accepts a command or write beat this cycle.
- bmem_rdata_i  in  BURST_WIDTH  read beat data.
- bmem_rvalid_i  in  1  read beat valid.

Behaviour:
- Reset (async, any state): state=S_IDLE; beat counter=0; latched data/addr/source=0; all outputs 0 except req_ready_o=1 (it follows S_IDLE).
- States:
  - S_IDLE: on accept, latch line address (addr & ~31), source, bus_tx, req_excl_i.
    - GETS/GETM → S_RD_CMD.
    - PUTM → S_WB_WAIT.
    - NONE or valid=0 → stay; NONE is dropped.
  - S_RD_CMD: bmem_read_o=1 with bmem_addr_o. Leave for S_RD_BEAT in the cycle after bmem_ready_i=1; hold while ready=0.
  - S_RD_BEAT: each bmem_rvalid_i writes data[64*cnt +: 64] and increments cnt. The beat with cnt=BURST_LEN-1 → S_RESP, cnt←0.
  - S_WB_WAIT: wait for wb_i.valid && wb_i.memory_flag && (wb_i.addr & ~31)==latched addr.
    - Latch wb_i.data, then → S_WR_BEAT.
    - Non-matching wb_i is ignored, with no state change.
  - S_WR_BEAT: bmem_write_o=1, bmem_addr_o=line addr, bmem_wdata_o=data[64*cnt +: 64].
    - Advance cnt on bmem_ready_i; stall otherwise.
    - Last accepted beat → S_RESP, cnt←0.
  - S_RESP: resp_o.valid=1 with these fields:
    - source=MEM_ID, destination=latched source, memory_flag=0, way=0, addr=line addr.
    - data=assembled line for reads, 0 for PUTM.
    - mmsg: GETS → EXCLUSIVE if req_excl_i was latched high, else DATA; GETM → DATA; PUTM → NODATA.
    - Hold all fields until resp_ready_i, then → S_IDLE in the next cycle.
- Latency (memory ready immediately, rvalid back-to-back from cycle N): resp_o.valid rises 1 cycle after the last read beat. PUTM with wb_i present and ready=1: resp_o.valid after 1 wb cycle + 4 write cycles.
- Stray input: bmem_rvalid_i outside S_RD_BEAT is ignored; the bench asserts this never happens.
- Gaps: rvalid gaps are allowed and cnt holds across them.
- Single outstanding transaction only. Upstream must hold req_i until accepted; requests arriving while busy are neither lost nor reordered by this block.
- Same-cycle resp accept and new req_i.valid: req_ready_o is still 0 that cycle, so the request is accepted no earlier than the next cycle.

Decomposition:
- Add to cache_types:
  - mem_resp_state_t enum {S_IDLE, S_RD_CMD, S_RD_BEAT, S_WB_WAIT, S_WR_BEAT, S_RESP}, logic [2:0].
  - LINE_OFFSET_BITS = $clog2(CACHELINE_SIZE/8) (=5).
  - BURST_LEN.
- Optional sub-module line_beat_buffer: a 256-bit register with a beat counter and load/shift controls, shared by the deserialize and serialize paths. Otherwise single module.

Test Plan:
- Read, exclusive: GETS addr 0x0000_1234, source 3, req_excl_i=1; memory returns beats 0x11..,0x22..,0x33..,0x44.. → bmem_addr_o=0x0000_1220; resp_o has dest=3, source=8, mmsg=EXCLUSIVE, data={0x44..,0x33..,0x22..,0x11..}.
- Read, modified, stalls: GETM source 5 with bmem_ready_i low 3 cycles and rvalid gaps → bmem_read_o held 4 cycles; mmsg=DATA; beats placed in order.
- Writeback with filtering: PUTM 0x8000_0040 source 2. wb_i for 0x8000_0060 is ignored; matching wb_i with data 0xA5...A5 follows → 4 write beats low-first, with stalls honored; then resp mmsg=NODATA, dest=2.
- Response backpressure: resp_ready_i low 5 cycles → resp_o stable; req_ready_o=0 throughout; S_IDLE one cycle after accept.
- Reset mid-burst: assert rst after read beat 2 → outputs 0 immediately. A fresh GETS completes with correct data and no stale beats.
- NONE/invalid: req_i.valid=1 with bus_tx=NONE → no memory command, no response, req_ready_o remains 1.
